// File: rtl/step_fsm_ctrl.sv
// Step-driven 9-state sequence detector with synchronized, debounced button input.
// Optional STEP_COUNT_EN macro adds an 8-bit accepted-step counter output.
module step_fsm_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_btn,
    input  logic       w,
    input  logic       clr,
    output logic       step_pulse,
    output logic [8:0] state_oh,
`ifdef STEP_COUNT_EN
    output logic       z,
    output logic [7:0] step_count
`else
    output logic       z
`endif
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [8:0] {
        ST_A = 9'b000000001,
        ST_B = 9'b000000010,
        ST_C = 9'b000000100,
        ST_D = 9'b000001000,
        ST_E = 9'b000010000,
        ST_F = 9'b000100000,
        ST_G = 9'b001000000,
        ST_H = 9'b010000000,
        ST_I = 9'b100000000
    } state_e;

    logic             btn_meta_q, btn_sync_q;
    logic             w_meta_q, w_sync_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    state_e           state_q, state_d;
    logic             z_q, z_d;

    // Two-flop synchronizers for the asynchronous button and data switch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            w_meta_q   <= 1'b0;
            w_sync_q   <= 1'b0;
        end else begin
            btn_meta_q <= step_btn;
            btn_sync_q <= btn_meta_q;
            w_meta_q   <= w;
            w_sync_q   <= w_meta_q;
        end
    end

    // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive disagreeing clocks
    always_comb begin
        deb_d   = deb_q;
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (btn_sync_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d   = btn_sync_q;
                pulse_d = btn_sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q   <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // Next state: zero-run walks B..E, one-run walks F..I; illegal codes fall back to A
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_A: if (pulse_q) state_d = w_sync_q ? ST_F : ST_B;
            ST_B: if (pulse_q) state_d = w_sync_q ? ST_F : ST_C;
            ST_C: if (pulse_q) state_d = w_sync_q ? ST_F : ST_D;
            ST_D: if (pulse_q) state_d = w_sync_q ? ST_F : ST_E;
            ST_E: if (pulse_q) state_d = w_sync_q ? ST_F : ST_E;
            ST_F: if (pulse_q) state_d = w_sync_q ? ST_G : ST_B;
            ST_G: if (pulse_q) state_d = w_sync_q ? ST_H : ST_B;
            ST_H: if (pulse_q) state_d = w_sync_q ? ST_I : ST_B;
            ST_I: if (pulse_q) state_d = w_sync_q ? ST_I : ST_B;
            default: state_d = ST_A;
        endcase
        if (clr) begin
            state_d = ST_A;
        end
        z_d = (state_d == ST_E) || (state_d == ST_I);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_A;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
        end
    end

    assign step_pulse = pulse_q;
    assign state_oh   = state_q;
    assign z          = z_q;

`ifdef STEP_COUNT_EN
    logic [7:0] step_cnt_q, step_cnt_d;

    // Accepted-step counter; clear beats a coincident step, wraps naturally at 8 bits
    always_comb begin
        step_cnt_d = step_cnt_q;
        if (clr) begin
            step_cnt_d = '0;
        end else if (pulse_q) begin
            step_cnt_d = step_cnt_q + 8'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt_q <= '0;
        end else begin
            step_cnt_q <= step_cnt_d;
        end
    end

    assign step_count = step_cnt_q;
`endif

endmodule

// File: tb/tb_step_fsm_ctrl.sv
// Self-checking bench for step_fsm_ctrl (DEBOUNCE_CYCLES=4); define STEP_COUNT_EN to cover the counter.
module tb_step_fsm_ctrl;

    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step_btn = 1'b0;
    logic       w = 1'b0;
    logic       clr = 1'b0;
    logic       step_pulse;
    logic [8:0] state_oh;
    logic       z;
`ifdef STEP_COUNT_EN
    logic [7:0] step_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    step_fsm_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_btn   (step_btn),
        .w          (w),
        .clr        (clr),
        .step_pulse (step_pulse),
        .state_oh   (state_oh),
`ifdef STEP_COUNT_EN
        .z          (z),
        .step_count (step_count)
`else
        .z          (z)
`endif
    );

    // Model: sample histories, N-in-a-row acceptance, and a run-length view of the detector
    bit bq[$];
    bit wq[$];
    bit svq[$];
    bit m_acc;
    bit m_pulse;
    int m_run;
    bit m_runw;
    int m_cnt;

    always @(posedge clk or negedge rst_n) begin
        bit sv;
        bit wv;
        bit all_diff;
        if (!rst_n) begin
            bq = {};
            wq = {};
            svq = {};
            bq.push_back(1'b0); bq.push_back(1'b0);
            wq.push_back(1'b0); wq.push_back(1'b0);
            m_acc = 1'b0;
            m_pulse = 1'b0;
            m_run = 0;
            m_runw = 1'b0;
            m_cnt = 0;
        end else begin
            sv = bq[bq.size()-2];
            wv = wq[wq.size()-2];
            if (clr) begin
                m_run = 0;
                m_cnt = 0;
            end else if (m_pulse) begin
                if (m_run > 0 && m_runw == wv) m_run = (m_run < 4) ? m_run + 1 : 4;
                else m_run = 1;
                m_runw = wv;
                m_cnt = (m_cnt + 1) % 256;
            end
            svq.push_back(sv);
            if (svq.size() > N) void'(svq.pop_front());
            all_diff = (svq.size() == N);
            foreach (svq[i]) if (svq[i] == m_acc) all_diff = 1'b0;
            m_pulse = 1'b0;
            if (all_diff) begin
                m_acc = ~m_acc;
                m_pulse = m_acc;
            end
            bq.push_back(step_btn);
            wq.push_back(w);
            if (bq.size() > 3) void'(bq.pop_front());
            if (wq.size() > 3) void'(wq.pop_front());
        end
    end

    function automatic logic [8:0] exp_state();
        if (m_run == 0) return 9'h001;
        return 9'(1) << (m_runw ? 4 + m_run : m_run);
    endfunction

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("step_pulse", 9'(step_pulse), 9'(m_pulse));
            check("state_oh", state_oh, exp_state());
            check("z", 9'(z), 9'(m_run == 4));
`ifdef STEP_COUNT_EN
            check("step_count", 9'(step_count), 9'(m_cnt));
`endif
        end
    end

    always @(negedge clk) if (step_pulse === 1'b1) pulses++;

    task automatic press(input bit wv);
        w = wv;
        step_btn = 1'b1;
        repeat (8) @(negedge clk);
        step_btn = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_now(input string tag);
        check({tag, "_state"}, state_oh, 9'h001);
        check({tag, "_z"}, 9'(z), 9'h000);
        check({tag, "_pulse"}, 9'(step_pulse), 9'h000);
    endtask

    initial begin
        int p0;
        logic [8:0] seq_exp [4];
        @(negedge clk);
        chk_en = 1'b1;
        check_reset_now("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Bounce of 2-clock runs, then a steady hold
        p0 = pulses;
        for (int i = 0; i < 20; i++) begin
            step_btn = ((i / 2) % 2) == 0;
            @(negedge clk);
        end
        check("bounce_no_pulse", 9'(pulses - p0), 9'd0);
        step_btn = 1'b1;
        repeat (10) @(negedge clk);
        check("bounce_one_pulse", 9'(pulses - p0), 9'd1);
        check("bounce_state_b", state_oh, 9'h002);
        repeat (20) @(negedge clk);
        check("hold_one_pulse", 9'(pulses - p0), 9'd1);
        step_btn = 1'b0;
        repeat (8) @(negedge clk);

        // Run of zeros
        do_clr();
        check("clr_state_a", state_oh, 9'h001);
        seq_exp = '{9'h002, 9'h004, 9'h008, 9'h010};
        for (int i = 0; i < 4; i++) begin
            press(1'b0);
            check("zeros_state", state_oh, seq_exp[i]);
            check("zeros_z", 9'(z), 9'(i == 3));
        end
        press(1'b0);
        check("zeros_hold_e", state_oh, 9'h010);
        check("zeros_hold_z", 9'(z), 9'h001);

        // Switch run from E
        seq_exp = '{9'h020, 9'h040, 9'h080, 9'h100};
        for (int i = 0; i < 4; i++) begin
            press(1'b1);
            check("ones_state", state_oh, seq_exp[i]);
            check("ones_z", 9'(z), 9'(i == 3));
        end
        press(1'b0);
        check("back_to_b", state_oh, 9'h002);
        check("back_to_b_z", 9'(z), 9'h000);

        // Clear coincident with a step from D
        do_clr();
        for (int i = 0; i < 3; i++) press(1'b0);
        check("at_d", state_oh, 9'h008);
        w = 1'b0;
        step_btn = 1'b1;
        repeat (6) @(negedge clk);
        check("sim_pulse_seen", 9'(step_pulse), 9'h001);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("sim_clr_state", state_oh, 9'h001);
`ifdef STEP_COUNT_EN
        check("sim_clr_count", 9'(step_count), 9'h000);
`endif
        step_btn = 1'b0;
        repeat (8) @(negedge clk);

        // Reset mid-press with button still held at release
        p0 = pulses;
        step_btn = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_now("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("held_after_reset_pulses", 9'(pulses - p0), 9'd1);
        check("held_after_reset_state", state_oh, 9'h002);
        step_btn = 1'b0;
        repeat (8) @(negedge clk);

`ifdef STEP_COUNT_EN
        do_clr();
        for (int i = 0; i < 256; i++) press(1'b0);
        check("wrap_256", 9'(step_count), 9'h000);
        press(1'b0);
        check("wrap_257", 9'(step_count), 9'h001);
`endif

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
